// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine and its job sequencer.
package gcd_pkg;

    localparam int GCD_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        BUSY,
        RESP
    } seq_state_t;

endpackage

// File: rtl/gcd_timeout_ctr.sv
// Loadable down-counter bounding how long one engine job may run.
module gcd_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;
    logic          running;

    // Loaded with TIMEOUT-1 so that it reads zero on the last allowed cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= CW'(TIMEOUT - 1);
        end else if (running && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = running && (count == '0);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Valid/ready front end for the go/done GCD engine: one job in flight,
// zero-operand bypass, stale-done guard and timeout abort.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             eng_go,
    output logic [WIDTH-1:0] eng_in1,
    output logic [WIDTH-1:0] eng_in2,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_timeout,
    output logic             res_bypass,
    output logic [CNT_W-1:0] jobs_done
);

    seq_state_t state;
    seq_state_t state_nx;

    logic load_eng;
    logic load_bypass;
    logic capture;
    logic abort;
    logic res_take;
    logic expired;

    gcd_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .start  (load_eng),
        .clear  (state == RESP),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        load_eng    = 1'b0;
        load_bypass = 1'b0;
        capture     = 1'b0;
        abort       = 1'b0;
        res_take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_a == '0 || req_b == '0) begin
                        load_bypass = 1'b1;
                        state_nx    = RESP;
                    end else begin
                        load_eng = 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: state_nx = ARM;
            // A done left high by the previous job must drop before we listen.
            ARM: begin
                if (expired) begin
                    abort    = 1'b1;
                    state_nx = RESP;
                end else if (!eng_done) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (eng_done) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else if (expired) begin
                    abort    = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_take = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_in1     <= '0;
            eng_in2     <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            res_bypass  <= 1'b0;
            jobs_done   <= '0;
        end else begin
            if (load_eng) begin
                eng_in1 <= req_a;
                eng_in2 <= req_b;
            end
            if (load_bypass) begin
                res_data   <= req_a | req_b;
                res_bypass <= 1'b1;
            end
            if (capture) begin
                res_data <= eng_out;
            end
            if (abort) begin
                res_data    <= '0;
                res_timeout <= 1'b1;
            end
            if (res_take) begin
                res_timeout <= 1'b0;
                res_bypass  <= 1'b0;
                jobs_done   <= jobs_done + 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign eng_go    = (state == ISSUE);
    assign res_valid = (state == RESP);

endmodule
